spart_driver: RTL and testbench

Processor-side bus master that sits opposite the SPART's bus interface and drives its `iocs`/`iorw`/`ioaddr`/`databus` port. After reset it programs the baud divisor from a 2-bit board switch setting, then runs a polled echo loop: it waits for `rda`, reads the received byte, waits for `tbr` and writes the byte back for transmission. It replaces the CPU in board-level loopback bring-up and gives a known-good initiator for SPART regression.

---
 rtl/spart_driver.sv | 144 ++++++++++++++
 tb/tb_spart_driver.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/spart_driver.sv
// rtl/spart_driver.sv - SPART bus master: divisor programming then polled RX->TX echo loop
`timescale 1ns/1ps
module spart_driver #(
  parameter logic [15:0] DB_0 = 16'd1301,
  parameter logic [15:0] DB_1 = 16'd650,
  parameter logic [15:0] DB_2 = 16'd324,
  parameter logic [15:0] DB_3 = 16'd161
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic [7:0] last_byte,
  output logic [7:0] echo_count
);

  typedef enum logic [2:0] {
    CFG_LO   = 3'd0,
    CFG_HI   = 3'd1,
    WAIT_RX  = 3'd2,
    READ_RX  = 3'd3,
    WAIT_TX  = 3'd4,
    WRITE_TX = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  sync1_q, cfg_s_q, cfg_cur_q;
  logic [15:0] db_sel;
  logic        iocs_q, iocs_d;
  logic        iorw_q, iorw_d;
  logic [1:0]  ioaddr_q, ioaddr_d;
  logic [7:0]  dout_q, dout_d;
  logic [7:0]  hold_q;
  logic [7:0]  echo_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 2'b00;
      cfg_s_q <= 2'b00;
    end else begin
      sync1_q <= br_cfg;
      cfg_s_q <= sync1_q;
    end
  end

  always_comb begin
    db_sel = DB_0;
    case (cfg_s_q)
      2'b00:   db_sel = DB_0;
      2'b01:   db_sel = DB_1;
      2'b10:   db_sel = DB_2;
      default: db_sel = DB_3;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= CFG_LO;
    else      state_q <= state_d;
  end

  // state_q is the access currently on the bus; outputs are registered from state_d
  always_comb begin
    state_d = state_q;
    case (state_q)
      // Reset parks here with no write issued yet, so stay one more cycle to issue it
      CFG_LO:   state_d = iocs_q ? CFG_HI : CFG_LO;
      CFG_HI:   state_d = WAIT_RX;
      WAIT_RX: begin
        if (cfg_s_q != cfg_cur_q) state_d = CFG_LO;
        else if (rda)             state_d = READ_RX;
      end
      READ_RX:  state_d = WAIT_TX;
      WAIT_TX:  state_d = tbr ? WRITE_TX : WAIT_TX;
      WRITE_TX: state_d = WAIT_RX;
      default:  state_d = CFG_LO;
    endcase
  end

  always_comb begin
    iocs_d   = 1'b0;
    iorw_d   = 1'b1;
    ioaddr_d = 2'b00;
    dout_d   = 8'h00;
    case (state_d)
      CFG_LO: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = 2'b10;
        dout_d   = db_sel[7:0];
      end
      CFG_HI: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = 2'b11;
        dout_d   = db_sel[15:8];
      end
      READ_RX: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b1;
        ioaddr_d = 2'b00;
      end
      WRITE_TX: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = 2'b00;
        dout_d   = hold_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iocs_q    <= 1'b0;
      iorw_q    <= 1'b1;
      ioaddr_q  <= 2'b00;
      dout_q    <= 8'h00;
      hold_q    <= 8'h00;
      echo_q    <= 8'h00;
      cfg_cur_q <= 2'b00;
    end else begin
      iocs_q   <= iocs_d;
      iorw_q   <= iorw_d;
      ioaddr_q <= ioaddr_d;
      dout_q   <= dout_d;
      if (state_q == READ_RX)  hold_q    <= databus;
      if (state_d == WRITE_TX) echo_q    <= echo_q + 8'd1;
      if (state_d == CFG_HI)   cfg_cur_q <= cfg_s_q;
    end
  end

  assign databus    = (iocs_q && !iorw_q) ? dout_q : 8'hzz;
  assign iocs       = iocs_q;
  assign iorw       = iorw_q;
  assign ioaddr     = ioaddr_q;
  assign last_byte  = hold_q;
  assign echo_count = echo_q;

endmodule

// File: tb/tb_spart_driver.sv
// tb/tb_spart_driver.sv - directed bench for spart_driver with a minimal SPART bus model
`timescale 1ns/1ps
module tb_spart_driver;

  logic       clk;
  logic       rst;
  logic [1:0] br_cfg;
  logic       rda;
  logic       tbr;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [7:0] last_byte;
  logic [7:0] echo_count;
  logic [7:0] rx_byte;

  int n_checks = 0;
  int n_pass   = 0;
  int bus_viol = 0;

  spart_driver dut (
    .clk        (clk),
    .rst        (rst),
    .br_cfg     (br_cfg),
    .rda        (rda),
    .tbr        (tbr),
    .iocs       (iocs),
    .iorw       (iorw),
    .ioaddr     (ioaddr),
    .databus    (databus),
    .last_byte  (last_byte),
    .echo_count (echo_count)
  );

  // SPART side drives the RX buffer only while the master reads address 00
  assign databus = (iocs && iorw && ioaddr == 2'b00) ? rx_byte : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (iorw && !(iocs && ioaddr == 2'b00) && databus !== 8'hzz) bus_viol++;
    if (iocs && iorw && $isunknown(databus)) bus_viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wait_access(input int budget, output bit ok, output int cyc,
                             output logic rw, output logic [1:0] addr, output logic [7:0] data);
    ok = 1'b0; cyc = 0; rw = 1'b0; addr = 2'b00; data = 8'h00;
    for (int i = 1; i <= budget && !ok; i++) begin
      @(negedge clk);
      if (iocs) begin
        ok = 1'b1; cyc = i; rw = iorw; addr = ioaddr; data = databus;
      end
    end
  endtask

  task automatic expect_access(input string tag, input logic exp_rw, input logic [1:0] exp_addr,
                               input logic [7:0] exp_data, input int exp_cyc);
    bit ok; int cyc; logic rw; logic [1:0] addr; logic [7:0] data;
    wait_access(20, ok, cyc, rw, addr, data);
    check({tag, "_seen"}, 32'(ok), 32'd1);
    check({tag, "_rw"},   32'(rw), 32'(exp_rw));
    check({tag, "_addr"}, 32'(addr), 32'(exp_addr));
    check({tag, "_data"}, 32'(data), 32'(exp_data));
    check({tag, "_cyc"},  32'(cyc), 32'(exp_cyc));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_iocs"},   32'(iocs), 32'd0);
    check({tag, "_iorw"},   32'(iorw), 32'd1);
    check({tag, "_ioaddr"}, 32'(ioaddr), 32'd0);
    check({tag, "_bus_z"},  {24'h0, databus}, {24'h0, 8'hzz});
    check({tag, "_last"},   32'(last_byte), 32'd0);
    check({tag, "_count"},  32'(echo_count), 32'd0);
  endtask

  initial begin
    bit ok; int cyc; logic rw; logic [1:0] addr; logic [7:0] data;
    int quiet_err; int loop_err; int gap_w; int gap_r;
    logic [7:0] exp_b;

    rst = 1'b0; br_cfg = 2'b01; rda = 1'b0; tbr = 1'b0; rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Synchronizer starts at 00, so DB_0 goes out first, then the 01 divisor 650 = 0x028A
    rst = 1'b1;
    expect_access("init_lo0", 1'b0, 2'b10, 8'h15, 1);
    expect_access("init_hi0", 1'b0, 2'b11, 8'h05, 1);
    expect_access("init_lo1", 1'b0, 2'b10, 8'h8A, 2);
    expect_access("init_hi1", 1'b0, 2'b11, 8'h02, 1);
    wait_access(20, ok, cyc, rw, addr, data);
    check("quiet_after_cfg", 32'(ok), 32'd0);

    rx_byte = 8'h5A; tbr = 1'b1; rda = 1'b1;
    expect_access("echo_rd", 1'b1, 2'b00, 8'h5A, 1);
    rda = 1'b0;
    expect_access("echo_wr", 1'b0, 2'b00, 8'h5A, 2);
    check("echo_last",  32'(last_byte), 32'h5A);
    check("echo_count", 32'(echo_count), 32'd1);

    tbr = 1'b0; rx_byte = 8'hC3; rda = 1'b1;
    expect_access("hold_rd", 1'b1, 2'b00, 8'hC3, 2);
    rda = 1'b0;
    quiet_err = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (iocs || databus !== 8'hzz) quiet_err++;
    end
    check("hold_quiet", 32'(quiet_err), 32'd0);
    check("hold_last",  32'(last_byte), 32'hC3);
    tbr = 1'b1;
    expect_access("hold_wr", 1'b0, 2'b00, 8'hC3, 1);

    tbr = 1'b0; rx_byte = 8'h3C; rda = 1'b1;
    expect_access("cfgchg_rd", 1'b1, 2'b00, 8'h3C, 2);
    rda = 1'b0; br_cfg = 2'b11;
    wait_access(10, ok, cyc, rw, addr, data);
    check("cfgchg_wait_tx_quiet", 32'(ok), 32'd0);
    tbr = 1'b1;
    expect_access("cfgchg_wr", 1'b0, 2'b00, 8'h3C, 1);
    expect_access("cfgchg_lo", 1'b0, 2'b10, 8'hA1, 2);
    expect_access("cfgchg_hi", 1'b0, 2'b11, 8'h00, 1);

    // 253 more echoes take echo_count from 3 through 255 to 0
    rda = 1'b1; loop_err = 0; gap_w = 0; gap_r = 0; exp_b = 8'h00;
    for (int i = 0; i < 253; i++) begin
      exp_b = 8'(i) ^ 8'hA5;
      rx_byte = exp_b;
      wait_access(20, ok, cyc, rw, addr, data);
      if (!ok || rw !== 1'b1 || addr !== 2'b00 || data !== exp_b) loop_err++;
      if (i == 0 && cyc != 2) loop_err++;
      if (i == 1) gap_r = cyc;
      wait_access(20, ok, cyc, rw, addr, data);
      if (!ok || rw !== 1'b0 || addr !== 2'b00 || data !== exp_b) loop_err++;
      if (i == 0) gap_w = cyc;
    end
    rda = 1'b0;
    check("loop_err",     32'(loop_err), 32'd0);
    check("loop_period",  32'(gap_w + gap_r), 32'd4);
    check("wrap_count",   32'(echo_count), 32'd0);
    check("wrap_last",    32'(last_byte), 32'(exp_b));

    tbr = 1'b0; rx_byte = 8'h77; rda = 1'b1;
    expect_access("rst_rd", 1'b1, 2'b00, 8'h77, 2);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    expect_access("rel_lo0", 1'b0, 2'b10, 8'h15, 1);
    expect_access("rel_hi0", 1'b0, 2'b11, 8'h05, 1);
    expect_access("rel_lo1", 1'b0, 2'b10, 8'hA1, 2);
    expect_access("rel_hi1", 1'b0, 2'b11, 8'h00, 1);
    expect_access("rel_rd",  1'b1, 2'b00, 8'h77, 2);
    rda = 1'b0;

    check("bus_contention", 32'(bus_viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
